// File: rtl/sprite_sdr_arbiter.sv
// Two-requester arbiter for the 64-bit sprite-ROM SDRAM channel (CLK_96M domain).
// One SDRAM transaction outstanding at a time; each requester can queue one request.
module sprite_sdr_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK_96M,
  input  logic        RESET_N,
  input  logic        req0,
  input  logic [24:0] addr0,
  output logic        rdy0,
  output logic [63:0] data0,
  input  logic        req1,
  input  logic [24:0] addr1,
  output logic        rdy1,
  output logic [63:0] data1,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic [63:0] sdr_data,
  input  logic        sdr_rdy,
  output logic        busy,
  output logic        owner,
  output logic        timeout_err,
  output logic        overrun,
  input  logic        clr_err
);

  // state   | meaning
  // ST_IDLE | no transaction outstanding; grant from registered pending flags
  // ST_WAIT | sdr_req issued for owner; waiting for sdr_rdy or timer expiry
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic        pending0;
  logic        pending1;
  logic [24:0] addr0_q;
  logic [24:0] addr1_q;
  logic        last_served;
  logic [9:0]  timer;

  logic grant;
  logic grant_sel;
  logic done;
  logic expired;
  logic done0;
  logic done1;
  logic accept0;
  logic accept1;
  logic overrun_evt;

  always_ff @(posedge CLK_96M or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_sel = 1'b0;
    done      = 1'b0;
    expired   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending0 || pending1) begin
          grant   = 1'b1;
          state_d = ST_WAIT;
          if (pending0 && pending1)
            grant_sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_served;
          else
            grant_sel = pending1;
        end
      end
      ST_WAIT: begin
        if (sdr_rdy) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (timer == TIMER_LAST) begin
          done    = 1'b1;
          expired = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q == ST_WAIT);
  assign done0 = done & ~owner;
  assign done1 = done & owner;

  // A request landing on its own completion cycle refills the latch instead of overrunning.
  assign accept0     = req0 & (~pending0 | done0);
  assign accept1     = req1 & (~pending1 | done1);
  assign overrun_evt = (req0 & ~accept0) | (req1 & ~accept1);

  always_ff @(posedge CLK_96M or negedge RESET_N) begin
    if (!RESET_N) begin
      pending0 <= 1'b0;
      pending1 <= 1'b0;
      addr0_q  <= '0;
      addr1_q  <= '0;
    end else begin
      if (accept0) begin
        pending0 <= 1'b1;
        addr0_q  <= addr0;
      end else if (done0) begin
        pending0 <= 1'b0;
      end
      if (accept1) begin
        pending1 <= 1'b1;
        addr1_q  <= addr1;
      end else if (done1) begin
        pending1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_96M or negedge RESET_N) begin
    if (!RESET_N) begin
      sdr_req     <= 1'b0;
      sdr_addr    <= '0;
      owner       <= 1'b0;
      timer       <= '0;
      last_served <= 1'b1;
    end else begin
      sdr_req <= grant;
      if (grant) begin
        sdr_addr <= grant_sel ? addr1_q : addr0_q;
        owner    <= grant_sel;
        timer    <= '0;
      end else if (state_q == ST_WAIT) begin
        timer <= timer + 10'd1;
      end
      if (done) last_served <= owner;
    end
  end

  always_ff @(posedge CLK_96M or negedge RESET_N) begin
    if (!RESET_N) begin
      rdy0  <= 1'b0;
      rdy1  <= 1'b0;
      data0 <= '0;
      data1 <= '0;
    end else begin
      rdy0 <= done0;
      rdy1 <= done1;
      if (done0) data0 <= expired ? 64'd0 : sdr_data;
      if (done1) data1 <= expired ? 64'd0 : sdr_data;
    end
  end

  // A fresh error event outranks a simultaneous clear.
  always_ff @(posedge CLK_96M or negedge RESET_N) begin
    if (!RESET_N) begin
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (expired)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
      if (overrun_evt)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_sdr_arbiter.sv
// Bench for sprite_sdr_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_sprite_sdr_arbiter;
  localparam int          TMO = 8;
  localparam logic [24:0] A_S = 25'h0012340;
  localparam logic [24:0] A_T = 25'h0ABCDE8;
  localparam logic [63:0] D_S = 64'hDEADBEEF_01234567;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        a_req0 = 1'b0, a_req1 = 1'b0, a_sdr_rdy = 1'b0, a_clr = 1'b0;
  logic [24:0] a_addr0 = '0, a_addr1 = '0;
  logic [63:0] a_sdr_data = '0;
  logic        a_rdy0, a_rdy1, a_sdr_req, a_busy, a_owner, a_terr, a_ovr;
  logic [63:0] a_data0, a_data1;
  logic [24:0] a_sdr_addr;

  logic        b_req0 = 1'b0, b_req1 = 1'b0, b_sdr_rdy = 1'b0, b_clr = 1'b0;
  logic [24:0] b_addr0 = '0, b_addr1 = '0;
  logic [63:0] b_sdr_data = '0;
  logic        b_rdy0, b_rdy1, b_sdr_req, b_busy, b_owner, b_terr, b_ovr;
  logic [63:0] b_data0, b_data1;
  logic [24:0] b_sdr_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sprite_sdr_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TMO)) dut_a (
    .CLK_96M(clk), .RESET_N(rst_n),
    .req0(a_req0), .addr0(a_addr0), .rdy0(a_rdy0), .data0(a_data0),
    .req1(a_req1), .addr1(a_addr1), .rdy1(a_rdy1), .data1(a_data1),
    .sdr_addr(a_sdr_addr), .sdr_req(a_sdr_req), .sdr_data(a_sdr_data), .sdr_rdy(a_sdr_rdy),
    .busy(a_busy), .owner(a_owner), .timeout_err(a_terr), .overrun(a_ovr), .clr_err(a_clr)
  );

  sprite_sdr_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TMO)) dut_b (
    .CLK_96M(clk), .RESET_N(rst_n),
    .req0(b_req0), .addr0(b_addr0), .rdy0(b_rdy0), .data0(b_data0),
    .req1(b_req1), .addr1(b_addr1), .rdy1(b_rdy1), .data1(b_data1),
    .sdr_addr(b_sdr_addr), .sdr_req(b_sdr_req), .sdr_data(b_sdr_data), .sdr_rdy(b_sdr_rdy),
    .busy(b_busy), .owner(b_owner), .timeout_err(b_terr), .overrun(b_ovr), .clr_err(b_clr)
  );

  typedef struct {
    logic        rq0, rq1, srdy, clr;
    logic        e_req;
    logic [24:0] e_addr;
    logic        e_rdy0, e_rdy1;
    logic [63:0] e_d0;
    logic        e_busy, e_own, e_terr;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mkv(bit rq0, bit rq1, bit srdy, bit clr, bit ereq, logic [24:0] eaddr,
                               bit erdy0, bit erdy1, logic [63:0] ed0, bit ebusy, bit eown, bit eterr);
    vec_t v;
    v.rq0 = rq0; v.rq1 = rq1; v.srdy = srdy; v.clr = clr;
    v.e_req = ereq; v.e_addr = eaddr; v.e_rdy0 = erdy0; v.e_rdy1 = erdy1;
    v.e_d0 = ed0; v.e_busy = ebusy; v.e_own = eown; v.e_terr = eterr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: pending requests, one in-flight transaction tracked by its issue cycle.
  int          cyc;
  bit          m_pend[2];
  logic [24:0] m_addr[2];
  bit          m_busy, m_who, m_last;
  int          m_issue;
  logic        e_sdr_req, e_owner, e_terr, e_ovr;
  logic [24:0] e_sdr_addr;
  logic        e_rdy[2];
  logic [63:0] e_data[2];

  task automatic model_reset();
    cyc = 0; m_busy = 0; m_who = 0; m_last = 1; m_issue = 0;
    m_pend[0] = 0; m_pend[1] = 0; m_addr[0] = '0; m_addr[1] = '0;
    e_sdr_req = 0; e_owner = 0; e_terr = 0; e_ovr = 0; e_sdr_addr = '0;
    e_rdy[0] = 0; e_rdy[1] = 0; e_data[0] = '0; e_data[1] = '0;
  endtask

  task automatic model_step(input bit rq0, input logic [24:0] ad0, input bit rq1, input logic [24:0] ad1,
                            input bit srdy, input logic [63:0] sdat, input bit clr);
    bit done, tmo, grant, pick, ovr_ev;
    bit rq[2];
    logic [24:0] ad[2];
    rq[0] = rq0; rq[1] = rq1; ad[0] = ad0; ad[1] = ad1;
    done  = m_busy && (srdy || (cyc - m_issue == TMO - 1));
    tmo   = done && !srdy;
    grant = !m_busy && (m_pend[0] || m_pend[1]);
    pick  = (m_pend[0] && m_pend[1]) ? !m_last : m_pend[1];
    e_sdr_req = grant;
    e_rdy[0] = 0; e_rdy[1] = 0;
    ovr_ev = 0;
    if (grant) begin
      e_sdr_addr = m_addr[pick]; e_owner = pick; m_who = pick; m_issue = cyc + 1; m_busy = 1;
    end
    if (done) begin
      e_rdy[m_who] = 1; e_data[m_who] = tmo ? 64'd0 : sdat;
      m_last = m_who; m_busy = 0; m_pend[m_who] = 0;
    end
    for (int n = 0; n < 2; n++) begin
      if (rq[n]) begin
        if (!m_pend[n]) begin m_pend[n] = 1; m_addr[n] = ad[n]; end
        else ovr_ev = 1;
      end
    end
    if (ovr_ev) e_ovr = 1; else if (clr) e_ovr = 0;
    if (tmo) e_terr = 1; else if (clr) e_terr = 0;
    cyc++;
  endtask

  task automatic check_a_zero(input string tag);
    chk({tag, "_sdr_req"}, a_sdr_req, 0);
    chk({tag, "_sdr_addr"}, a_sdr_addr, 0);
    chk({tag, "_rdy0"}, a_rdy0, 0);
    chk({tag, "_rdy1"}, a_rdy1, 0);
    chk({tag, "_data0"}, a_data0, 0);
    chk({tag, "_data1"}, a_data1, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_owner"}, a_owner, 0);
    chk({tag, "_terr"}, a_terr, 0);
    chk({tag, "_ovr"}, a_ovr, 0);
  endtask

  initial begin
    int  resp_cnt;
    bit  seen;

    vt[0]  = mkv(1,0,0,0, 0,25'h0,0,0,64'h0,0,0,0);
    vt[1]  = mkv(0,0,0,0, 1,A_S,0,0,64'h0,1,0,0);
    for (int i = 2; i <= 6; i++) vt[i] = mkv(0,0,0,0, 0,A_S,0,0,64'h0,1,0,0);
    vt[7]  = mkv(0,0,1,0, 0,A_S,1,0,D_S,0,0,0);
    vt[8]  = mkv(0,0,0,0, 0,A_S,0,0,D_S,0,0,0);
    vt[9]  = mkv(0,1,0,0, 0,A_S,0,0,D_S,0,0,0);
    vt[10] = mkv(0,0,0,0, 1,A_T,0,0,D_S,1,1,0);
    for (int i = 11; i <= 17; i++) vt[i] = mkv(0,0,0,0, 0,A_T,0,0,D_S,1,1,0);
    vt[18] = mkv(0,0,0,0, 0,A_T,0,1,D_S,0,1,1);
    vt[19] = mkv(0,0,0,1, 0,A_T,0,0,D_S,0,1,0);
    vt[20] = mkv(0,0,0,0, 0,A_T,0,0,D_S,0,1,0);

    #1;
    check_a_zero("reset");
    chk("reset_b_owner", b_owner, 0);
    chk("reset_b_busy", b_busy, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single request, then a timeout on requester 1 (data bus deliberately non-zero).
    for (int i = 0; i < 21; i++) begin
      a_req0 = vt[i].rq0; a_addr0 = A_S; a_req1 = vt[i].rq1; a_addr1 = A_T;
      a_sdr_rdy = vt[i].srdy; a_sdr_data = D_S; a_clr = vt[i].clr;
      tick();
      chk($sformatf("vec%0d_sdr_req", i), a_sdr_req, vt[i].e_req);
      chk($sformatf("vec%0d_sdr_addr", i), a_sdr_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_rdy0", i), a_rdy0, vt[i].e_rdy0);
      chk($sformatf("vec%0d_rdy1", i), a_rdy1, vt[i].e_rdy1);
      chk($sformatf("vec%0d_data0", i), a_data0, vt[i].e_d0);
      chk($sformatf("vec%0d_data1", i), a_data1, 64'h0);
      chk($sformatf("vec%0d_busy", i), a_busy, vt[i].e_busy);
      chk($sformatf("vec%0d_owner", i), a_owner, vt[i].e_own);
      chk($sformatf("vec%0d_terr", i), a_terr, vt[i].e_terr);
      chk($sformatf("vec%0d_ovr", i), a_ovr, 0);
    end
    a_req0 = 0; a_req1 = 0; a_sdr_rdy = 0; a_clr = 0;

    // Round-robin ties, twice.
    do_reset();
    a_addr0 = 25'h1000008; a_addr1 = 25'h0200010;
    for (int r = 0; r < 2; r++) begin
      a_req0 = 1; a_req1 = 1; tick(); a_req0 = 0; a_req1 = 0; tick();
      chk("rr_first_sdr_req", a_sdr_req, 1);
      chk("rr_first_owner", a_owner, 0);
      chk("rr_first_addr", a_sdr_addr, 25'h1000008);
      tick();
      a_sdr_rdy = 1; a_sdr_data = 64'h1111 + 64'(r); tick(); a_sdr_rdy = 0;
      chk("rr_rdy0", a_rdy0, 1);
      chk("rr_data0", a_data0, 64'h1111 + 64'(r));
      tick();
      chk("rr_second_sdr_req", a_sdr_req, 1);
      chk("rr_second_owner", a_owner, 1);
      chk("rr_second_addr", a_sdr_addr, 25'h0200010);
      a_sdr_rdy = 1; a_sdr_data = 64'h2222 + 64'(r); tick(); a_sdr_rdy = 0;
      chk("rr_rdy1", a_rdy1, 1);
      chk("rr_data1", a_data1, 64'h2222 + 64'(r));
      tick();
    end
    chk("rr_no_overrun", a_ovr, 0);

    // Overrun, clear, clear-vs-event priority, and re-request on the rdy0 cycle.
    do_reset();
    a_addr0 = 25'h0000AA8; a_req0 = 1; tick();
    a_addr0 = 25'h1FFFFF8; tick(); a_req0 = 0;
    chk("ovr_flag", a_ovr, 1);
    chk("ovr_sdr_req", a_sdr_req, 1);
    chk("ovr_first_addr_kept", a_sdr_addr, 25'h0000AA8);
    a_clr = 1;
    for (int j = 0; j < 3; j++) begin
      tick(); a_clr = 0;
      chk("ovr_single_txn", a_sdr_req, 0);
    end
    chk("ovr_cleared", a_ovr, 0);
    a_sdr_rdy = 1; a_sdr_data = 64'hA5A5_0000_5A5A_0001; tick(); a_sdr_rdy = 0;
    chk("b2b_rdy0", a_rdy0, 1);
    chk("b2b_data0", a_data0, 64'hA5A5_0000_5A5A_0001);
    a_req0 = 1; a_addr0 = 25'h0155550; tick(); a_req0 = 0;
    chk("b2b_gap", a_sdr_req, 0);
    tick();
    chk("b2b_sdr_req", a_sdr_req, 1);
    chk("b2b_addr", a_sdr_addr, 25'h0155550);
    chk("b2b_no_overrun", a_ovr, 0);
    a_req0 = 1; a_clr = 1; tick(); a_req0 = 0; a_clr = 0;
    chk("ovr_event_beats_clr", a_ovr, 1);
    a_sdr_rdy = 1; tick(); a_sdr_rdy = 0;
    chk("b2b_second_rdy0", a_rdy0, 1);
    tick();

    // Asynchronous reset while waiting, then a late sdr_rdy.
    do_reset();
    a_addr1 = 25'h0F0F0F0; a_req1 = 1; tick(); a_req1 = 0; tick();
    a_sdr_rdy = 1; a_sdr_data = 64'hCAFE; tick(); a_sdr_rdy = 0;
    a_req1 = 1; tick(); a_req1 = 0; tick();
    a_req1 = 1; tick(); a_req1 = 0;
    chk("pre_reset_busy", a_busy, 1);
    chk("pre_reset_owner", a_owner, 1);
    chk("pre_reset_ovr", a_ovr, 1);
    chk("pre_reset_data1", a_data1, 64'hCAFE);
    rst_n = 0;
    #1;
    check_a_zero("async_rst");
    tick();
    rst_n = 1;
    tick();
    a_sdr_rdy = 1; tick(); a_sdr_rdy = 0;
    chk("late_rdy_rdy0", a_rdy0, 0);
    chk("late_rdy_rdy1", a_rdy1, 0);
    chk("late_rdy_busy", a_busy, 0);
    tick();
    chk("late_rdy_rdy1_next", a_rdy1, 0);

    // Fixed priority: requester 0 re-requests on each completion cycle and keeps winning.
    do_reset();
    b_addr0 = 25'h0000100; b_addr1 = 25'h0000200;
    b_req0 = 1; b_req1 = 1; tick(); b_req0 = 0; b_req1 = 0;
    for (int i = 0; i < 4; i++) begin
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        tick();
        if (b_sdr_req) seen = 1;
      end
      chk($sformatf("fp%0d_grant_seen", i), seen, 1);
      chk($sformatf("fp%0d_owner", i), b_owner, (i < 3) ? 1'b0 : 1'b1);
      b_sdr_rdy = 1; b_sdr_data = 64'hF00 + 64'(i); b_req0 = (i < 2);
      tick();
      b_sdr_rdy = 0; b_req0 = 0;
      chk($sformatf("fp%0d_rdy0", i), b_rdy0, (i < 3) ? 1'b1 : 1'b0);
      chk($sformatf("fp%0d_rdy1", i), b_rdy1, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("fp_data1", b_data1, 64'hF03);
    chk("fp_no_overrun", b_ovr, 0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    resp_cnt = -1;
    for (int i = 0; i < 3000; i++) begin
      a_req0 = ($urandom_range(0, 5) == 0);
      a_req1 = ($urandom_range(0, 5) == 0);
      a_addr0 = 25'($urandom);
      a_addr1 = 25'($urandom);
      a_clr = ($urandom_range(0, 29) == 0);
      a_sdr_data = {$urandom, $urandom};
      a_sdr_rdy = (resp_cnt == 0) || ($urandom_range(0, 99) == 0);
      if (resp_cnt >= 0) resp_cnt--;
      model_step(a_req0, a_addr0, a_req1, a_addr1, a_sdr_rdy, a_sdr_data, a_clr);
      tick();
      chk("rnd_sdr_req", a_sdr_req, e_sdr_req);
      chk("rnd_sdr_addr", a_sdr_addr, e_sdr_addr);
      chk("rnd_owner", a_owner, e_owner);
      chk("rnd_busy", a_busy, m_busy);
      chk("rnd_rdy0", a_rdy0, e_rdy[0]);
      chk("rnd_rdy1", a_rdy1, e_rdy[1]);
      chk("rnd_data0", a_data0, e_data[0]);
      chk("rnd_data1", a_data1, e_data[1]);
      chk("rnd_terr", a_terr, e_terr);
      chk("rnd_ovr", a_ovr, e_ovr);
      if (a_sdr_req) resp_cnt = $urandom_range(0, 10);
    end
    a_req0 = 0; a_req1 = 0; a_clr = 0; a_sdr_rdy = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
